spi_mem_slave: RTL and testbench

Parametrised SPI slave with an integrated single-port-write/registered-read memory. It decodes a 2-bit command followed by a payload per SS_n frame, keeps separate write and read address pointers, and shifts read data out on MISO. Successor to the fixed 8-bit SPI+RAM pair. Adds configurable widths and depth, abort detection, completion strobes and optional address auto-increment.

---
 rtl/spi_mem_pkg.sv | 21 ++
 rtl/spi_mem_slave_if.sv | 19 +
 rtl/spi_mem_array.sv | 35 +++
 rtl/spi_mem_slave.sv | 169 ++++++++++++++++
 tb/tb_spi_mem_slave.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_mem_pkg.sv
// Shared command codes, FSM state type and sizing helper for the SPI memory slave.
package spi_mem_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    PAYLOAD,
    TX,
    DONE
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_mem_slave_if.sv
// SPI pins plus frame status strobes of the memory slave; the slave modport faces the DUT.
interface spi_mem_slave_if;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic frame_done;
  logic frame_err;
  logic busy;

  modport slave (
    input  SS_n, MOSI,
    output MISO, frame_done, frame_err, busy
  );

  modport master (
    output SS_n, MOSI,
    input  MISO, frame_done, frame_err, busy
  );
endinterface

// File: rtl/spi_mem_array.sv
// Word memory: synchronous write, 1-cycle registered read, no reset on storage.
// Addresses at or beyond MEM_DEPTH drop writes and read back as zero.
module spi_mem_array #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_SIZE-1:0]  waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_SIZE-1:0]  raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  wr_ok;
  logic                  rd_ok;

  assign wr_ok = 32'(waddr_i) < MEM_DEPTH;
  assign rd_ok = 32'(raddr_i) < MEM_DEPTH;

  always_ff @(posedge clk) begin
    if (we_i && wr_ok) begin
      mem_q[waddr_i[IDX_W-1:0]] <= wdata_i;
    end
    rdata_q <= rd_ok ? mem_q[raddr_i[IDX_W-1:0]] : '0;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/spi_mem_slave.sv
// SPI slave decoding a 2-bit command + payload per SS_n frame into an internal memory.
// Optional SPI_MEM_AUTO_INC_EN: pointers advance after each committed data frame.
module spi_mem_slave
  import spi_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic           clk,
  input  logic           rst,
  spi_mem_slave_if.slave bus
);

  localparam int SH_W  = max2(ADDR_SIZE, DATA_WIDTH);
  localparam int CNT_W = $clog2(SH_W + 1);
  localparam logic [CNT_W-1:0] ADDR_LEN = CNT_W'(ADDR_SIZE);
  localparam logic [CNT_W-1:0] DATA_LEN = CNT_W'(DATA_WIDTH);

  state_e                 state_q, state_d;
  logic [1:0]             cmd_q, cmd_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SH_W-1:0]        sh_q, sh_d;
  logic [ADDR_SIZE-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_SIZE-1:0]   rd_addr_q, rd_addr_d;
  logic                   miso_q, miso_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   mem_we;
  logic [DATA_WIDTH-1:0]  mem_rdata;
  logic [CNT_W-1:0]       pay_len;

`ifdef SPI_MEM_AUTO_INC_EN
  function automatic logic [ADDR_SIZE-1:0] next_ptr(input logic [ADDR_SIZE-1:0] p);
    return (32'(p) == MEM_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
`endif

  assign pay_len = (cmd_q == CMD_WR_DATA) ? DATA_LEN : ADDR_LEN;

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    miso_d    = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.SS_n) begin
          state_d = CMD;
          cnt_d   = '0;
        end
      end
      CMD: begin
        if (bus.SS_n) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cmd_d = {cmd_q[0], bus.MOSI};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q != '0) begin
            cnt_d   = '0;
            state_d = ({cmd_q[0], bus.MOSI} == CMD_RD_DATA) ? TX : PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        // The commit edge wins over a simultaneous SS_n rise.
        if (cnt_q == pay_len) begin
          done_d  = 1'b1;
          state_d = bus.SS_n ? IDLE : DONE;
          case (cmd_q)
            CMD_WR_ADDR: wr_addr_d = sh_q[ADDR_SIZE-1:0];
            CMD_RD_ADDR: rd_addr_d = sh_q[ADDR_SIZE-1:0];
            CMD_WR_DATA: begin
              mem_we = 1'b1;
`ifdef SPI_MEM_AUTO_INC_EN
              wr_addr_d = next_ptr(wr_addr_q);
`endif
            end
            default: ;
          endcase
        end else if (bus.SS_n) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          sh_d  = {sh_q[SH_W-2:0], bus.MOSI};
          cnt_d = cnt_q + 1'b1;
        end
      end
      TX: begin
        if (cnt_q == DATA_LEN) begin
          done_d  = 1'b1;
          state_d = bus.SS_n ? IDLE : DONE;
`ifdef SPI_MEM_AUTO_INC_EN
          rd_addr_d = next_ptr(rd_addr_q);
`endif
        end else if (bus.SS_n) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          // First TX edge loads the registered read word and drives its MSB directly.
          if (cnt_q == '0) begin
            sh_d   = SH_W'(mem_rdata);
            miso_d = mem_rdata[DATA_WIDTH-1];
          end else begin
            sh_d   = sh_q << 1;
            miso_d = sh_q[DATA_WIDTH-2];
          end
        end
      end
      DONE: begin
        if (bus.SS_n) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      cnt_q     <= '0;
      sh_q      <= '0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      miso_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      miso_q    <= miso_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  spi_mem_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_SIZE (ADDR_SIZE),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_array (
    .clk    (clk),
    .we_i   (mem_we),
    .waddr_i(wr_addr_q),
    .wdata_i(sh_q[DATA_WIDTH-1:0]),
    .raddr_i(rd_addr_q),
    .rdata_o(mem_rdata)
  );

  assign bus.MISO       = miso_q;
  assign bus.frame_done = done_q;
  assign bus.frame_err  = err_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_spi_mem_slave.sv
// Frame-level reference model for spi_mem_slave; every edge's outputs are predicted from
// the frame shape (command, SS_n low length) and a word-array model of the memory.
`timescale 1ns/1ps
module tb_spi_mem_slave;
  import spi_mem_pkg::*;

  localparam int DW     = 8;
  localparam int AS     = 8;
  localparam int DEPTH  = 256;
  localparam int PDW    = 12;
  localparam int PAS    = 4;
  localparam int PDEPTH = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_mem_slave_if bus ();
  spi_mem_slave_if bus_p ();

  spi_mem_slave #(.DATA_WIDTH(DW), .ADDR_SIZE(AS), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  spi_mem_slave #(.DATA_WIDTH(PDW), .ADDR_SIZE(PAS), .MEM_DEPTH(PDEPTH)) dut_p (
    .clk(clk), .rst(rst), .bus(bus_p)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [DW-1:0]  mem_m [DEPTH];
  int             wr_m = 0;
  int             rd_m = 0;
  logic [DW-1:0]  cap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic ss, input logic mosi, input logic ss_p, input logic mosi_p);
    @(negedge clk);
    bus.SS_n   = ss;
    bus.MOSI   = mosi;
    bus_p.SS_n = ss_p;
    bus_p.MOSI = mosi_p;
    @(posedge clk);
    #1;
  endtask

  // One frame on the default DUT: SS_n low for L edges (E0..E(L-1)), then high for H edges.
  task automatic run_frame(input logic [1:0] cmd, input logic [31:0] payload,
                           input int L, input int H, input string tag);
    int           n;
    int           c;
    logic         compl;
    logic         mosi;
    logic         em;
    logic [DW-1:0] d;
    n     = (cmd == CMD_WR_DATA || cmd == CMD_RD_DATA) ? DW : AS;
    c     = 3 + n;
    compl = (L >= c);
    d     = (rd_m < DEPTH) ? mem_m[rd_m] : '0;
    cap   = '0;
    for (int i = 0; i < L + H; i++) begin
      if (i == 1) mosi = cmd[1];
      else if (i == 2) mosi = cmd[0];
      else if (i >= 3 && i <= 2 + n && cmd != CMD_RD_DATA) mosi = payload[n-1-(i-3)];
      else mosi = 1'($urandom_range(0, 1));
      tick(i >= L, mosi, 1'b1, 1'b0);
      em = (cmd == CMD_RD_DATA && i >= 3 && i <= 2 + DW && i < L) ? d[DW-1-(i-3)] : 1'b0;
      if (cmd == CMD_RD_DATA && i >= 3 && i <= 2 + DW) cap = {cap[DW-2:0], bus.MISO};
      check($sformatf("%s miso e%0d", tag, i), 32'(bus.MISO), 32'(em));
      check($sformatf("%s busy e%0d", tag, i), 32'(bus.busy), 32'(i < L));
      check($sformatf("%s done e%0d", tag, i), 32'(bus.frame_done), 32'(compl && i == c));
      check($sformatf("%s err e%0d", tag, i), 32'(bus.frame_err), 32'(!compl && i == L));
    end
    if (compl) begin
      case (cmd)
        CMD_WR_ADDR: wr_m = int'(payload[AS-1:0]);
        CMD_RD_ADDR: rd_m = int'(payload[AS-1:0]);
        CMD_WR_DATA: begin
          if (wr_m < DEPTH) mem_m[wr_m] = payload[DW-1:0];
`ifdef SPI_MEM_AUTO_INC_EN
          wr_m = (wr_m + 1) % DEPTH;
`endif
        end
        default: begin
`ifdef SPI_MEM_AUTO_INC_EN
          rd_m = (rd_m + 1) % DEPTH;
`endif
        end
      endcase
    end
  endtask

  task automatic full(input logic [1:0] cmd, input logic [31:0] payload, input string tag);
    int n;
    n = (cmd == CMD_WR_DATA || cmd == CMD_RD_DATA) ? DW : AS;
    run_frame(cmd, payload, 4 + n, 1, tag);
  endtask

  task automatic read_at(input int a, input string tag);
    full(CMD_RD_ADDR, 32'(a), tag);
    full(CMD_RD_DATA, 32'h0, tag);
  endtask

  // Non-default DUT: complete frame, returns shifted-out word and the edge frame_done was seen.
  task automatic frame_p(input logic [1:0] cmd, input logic [15:0] pl, input int n,
                         output logic [PDW-1:0] rd, output int done_at);
    logic mosi;
    rd      = '0;
    done_at = -1;
    for (int i = 0; i < n + 6; i++) begin
      if (i == 1) mosi = cmd[1];
      else if (i == 2) mosi = cmd[0];
      else if (i >= 3 && i <= 2 + n && cmd != CMD_RD_DATA) mosi = pl[n-1-(i-3)];
      else mosi = 1'b0;
      tick(1'b1, 1'b0, i >= n + 4, mosi);
      if (cmd == CMD_RD_DATA && i >= 3 && i <= 2 + n) rd = {rd[PDW-2:0], bus_p.MISO};
      if (bus_p.frame_done) done_at = i;
    end
  endtask

  initial begin
    logic [PDW-1:0] rdp;
    int             dat;
    logic [1:0]     cmd;
    int             n;
    int             L;

    bus.SS_n   = 1'b1;
    bus.MOSI   = 1'b0;
    bus_p.SS_n = 1'b1;
    bus_p.MOSI = 1'b0;

    #12;
    check("reset miso", 32'(bus.MISO), 32'h0);
    check("reset busy", 32'(bus.busy), 32'h0);
    check("reset done", 32'(bus.frame_done), 32'h0);
    check("reset err", 32'(bus.frame_err), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick(1'b1, 1'b0, 1'b1, 1'b0);

    full(CMD_WR_ADDR, 32'h2A, "basic wa");
    full(CMD_WR_DATA, 32'hC5, "basic wd");
    read_at(32'h2A, "basic rd");
    check("basic readback", 32'(cap), 32'hC5);

    full(CMD_WR_ADDR, 32'h10, "abort wa");
    full(CMD_WR_DATA, 32'h77, "abort wd");
    full(CMD_WR_ADDR, 32'h10, "abort wa2");
    run_frame(CMD_WR_DATA, 32'hFF, 7, 2, "abort cut");
    read_at(32'h10, "abort rd");
    check("abort keeps mem", 32'(cap), 32'h77);

    full(CMD_WR_ADDR, 32'h40, "tie wa");
    run_frame(CMD_WR_DATA, 32'h3C, 11, 2, "tie wd");
    read_at(32'h40, "tie rd");
    check("tie readback", 32'(cap), 32'h3C);

    full(CMD_WR_ADDR, 32'hFF, "inc wa");
    full(CMD_WR_DATA, 32'hA1, "inc wd1");
    full(CMD_WR_DATA, 32'hB2, "inc wd2");
    read_at(32'hFF, "inc rd ff");
`ifdef SPI_MEM_AUTO_INC_EN
    check("inc mem ff", 32'(cap), 32'hA1);
    read_at(32'h00, "inc rd 00");
    check("inc mem 00", 32'(cap), 32'hB2);
`else
    check("noinc mem ff", 32'(cap), 32'hB2);
`endif

    for (int a = 0; a < DEPTH; a++) begin
      run_frame(CMD_WR_ADDR, 32'(a), 11 + $urandom_range(0, 2), 1, "fill wa");
      run_frame(CMD_WR_DATA, $urandom, 11 + $urandom_range(0, 2), 1, "fill wd");
    end

    for (int k = 0; k < 300; k++) begin
      cmd = 2'($urandom_range(0, 3));
      n   = (cmd == CMD_WR_DATA || cmd == CMD_RD_DATA) ? DW : AS;
      if ($urandom_range(0, 4) == 0) L = $urandom_range(1, 2 + n);
      else L = 3 + n + $urandom_range(0, 3);
      run_frame(cmd, $urandom, L, $urandom_range(1, 3), "rand");
    end

    full(CMD_RD_ADDR, 32'($urandom_range(0, DEPTH - 1)), "rst ra");
    for (int i = 0; i < 7; i++) tick(1'b0, (i == 1 || i == 2), 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midtx rst miso", 32'(bus.MISO), 32'h0);
    check("midtx rst busy", 32'(bus.busy), 32'h0);
    check("midtx rst err", 32'(bus.frame_err), 32'h0);
    bus.SS_n = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    wr_m = 0;
    rd_m = 0;
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    full(CMD_RD_DATA, 32'h0, "post rst rd");
    full(CMD_WR_DATA, 32'h5A, "post rst wd");
    read_at(0, "post rst rd0");
    check("post rst wr ptr 0", 32'(cap), 32'h5A);

    frame_p(CMD_WR_ADDR, 16'd9, PAS, rdp, dat);
    check("p wa9 done edge", 32'(dat), 32'd7);
    frame_p(CMD_WR_DATA, 16'hABC, PDW, rdp, dat);
    check("p wd done edge", 32'(dat), 32'd15);
    frame_p(CMD_RD_ADDR, 16'd9, PAS, rdp, dat);
    frame_p(CMD_RD_DATA, 16'h0, PDW, rdp, dat);
    check("p read 9", 32'(rdp), 32'hABC);
    check("p rd done edge", 32'(dat), 32'd15);
    frame_p(CMD_WR_ADDR, 16'd12, PAS, rdp, dat);
    frame_p(CMD_WR_DATA, 16'h123, PDW, rdp, dat);
    check("p oob wd done edge", 32'(dat), 32'd15);
    frame_p(CMD_RD_ADDR, 16'd12, PAS, rdp, dat);
    frame_p(CMD_RD_DATA, 16'h0, PDW, rdp, dat);
    check("p read oob", 32'(rdp), 32'h000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
